id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter ALUOP_W, default 8, width of the ALU operation code.
REQ-002 Parameter ALUSEL_W, default 3, width of the ALU result selector.
REQ-003 Parameter REG_W, default 32, operand width.
REQ-004 Parameter ADDR_W, default 5, destination register address width.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset: synchronous, active-high.
REQ-007 flush  input  1  discard all held and incoming operations.
REQ-008 in_valid  input  1  decode stage presents an operation.
REQ-009 in_ready  output  1  stage accepts an operation this cycle; driven directly from a register.
REQ-010 id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg  input  ALUOP_W/ALUSEL_W/REG_W/REG_W/ADDR_W/1  decoded operation payload.
REQ-011 out_valid  output  1  execute-stage payload is valid.
REQ-012 out_ready  input  1  execute stage consumes the payload this cycle.
REQ-013 ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  output  same widths  payload to execute stage.
REQ-014 occupancy  output  2  entries held (0, 1 or 2).

Function
REQ-015 Accept = in_valid && in_ready; consume = out_valid && out_ready.
REQ-016 Storage is one main register plus one skid register; states EMPTY (0 entries), FULL (main only), SKID (main and skid).
REQ-017 EMPTY: accept -> FULL, main loaded; no accept -> stay EMPTY.
REQ-018 FULL: accept and consume -> FULL, main reloaded; accept only -> SKID, skid loaded; consume only -> EMPTY; neither -> hold.
REQ-019 SKID: consume -> FULL, skid contents move into main; otherwise hold; no accept possible.
REQ-020 in_ready = 1 in EMPTY and FULL, 0 in SKID; it does not depend combinationally on out_ready.
REQ-021 out_valid = 1 in FULL and SKID; ex_* always reflect main.
REQ-022 Input-to-output latency is exactly 1 cycle when the stage is empty; ordering is strictly FIFO.
REQ-023 Whenever out_valid = 0, ex_* drive NOP values: aluop NOP_OP, alusel RES_NOP, reg1/reg2 zero, wd NOP register address, wreg write-disable.
REQ-024 flush = 1: next state EMPTY, both entries discarded, any accept that cycle ignored, and in_ready = 1 on the following cycle.
REQ-025 Priority order: rst, then flush, then the handshake transitions.
REQ-026 The payload is not interpreted or modified; all widths pass through unchanged.

Reset
REQ-027 rst = 1 forces state EMPTY, out_valid 0, in_ready 1, occupancy 0, and NOP values on ex_* from the next edge onward.
REQ-028 Reset asserted mid-operation discards both entries, identical to flush.

Structure
REQ-029 The shared defines package holds the NOP_OP, RES_NOP, ZeroWord, NOPRegAddr and WriteDisable constants; the state encoding is local to the module.
REQ-030 A single sub-module, pipe_payload_reg (a width-parametrised load-enable register), is instantiated twice, as main and as skid.

Verification
REQ-031 From EMPTY, in_valid=1 with aluop=0x21, reg1=5, reg2=7, wd=3, wreg=1, and out_ready=1 -> next cycle out_valid=1 with the same payload, occupancy=1.
REQ-032 out_ready=0, two consecutive accepts A then B -> occupancy=2 and in_ready=0; then out_ready=1 -> A on cycle n, B on cycle n+1, then out_valid=0 and ex_wreg=0.
REQ-033 Streaming 8 operations with out_ready=1 throughout -> one output per cycle, in order, in_ready constantly 1.
REQ-034 In SKID, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, NOP outputs, incoming operation never appears.
REQ-035 rst asserted while FULL with out_ready=0 -> next cycle occupancy=0, ex_aluop=NOP_OP, ex_reg1=0, in_ready=1.
REQ-036 Random in_valid/out_ready at 50%, checked against a scoreboard -> no loss, duplication or reordering, and in_ready never 0 while occupancy < 2.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared defines for the decode/execute boundary.
// NOP payload constants driven when no operation is valid.
package id_ex_pipe_pkg;

  localparam logic [7:0]  NOP_OP       = 8'h00;
  localparam logic [2:0]  RES_NOP      = 3'b000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised load-enable payload register.
// Holds its value until load is asserted.
module pipe_payload_reg
  import id_ex_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture new payload only when loaded.
  always_ff @(posedge clk) begin
    if (load) q <= d;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a one-entry skid buffer.
// Ready is registered so it never depends on out_ready.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int REG_W    = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [REG_W-1:0]    id_reg1,
  input  logic [REG_W-1:0]    id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [REG_W-1:0]    ex_reg1,
  output logic [REG_W-1:0]    ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [1:0]          occupancy
);

  localparam int P =
    ALUOP_W + ALUSEL_W + 2 * REG_W + ADDR_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state, state_n;

  logic         accept, consume;
  logic         main_load, skid_load;
  logic [P-1:0] in_pl, main_d, main_q, skid_q;

  logic [ALUOP_W-1:0]  m_aluop;
  logic [ALUSEL_W-1:0] m_alusel;
  logic [REG_W-1:0]    m_reg1, m_reg2;
  logic [ADDR_W-1:0]   m_wd;
  logic                m_wreg;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  assign in_pl = {id_aluop, id_alusel, id_reg1,
                  id_reg2, id_wd, id_wreg};

  // Skid contents refill main when draining SKID.
  assign main_d = (state == SKID) ? skid_q : in_pl;

  // Next state and register loads from the handshake.
  always_comb begin
    state_n   = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_n   = FULL;
          main_load = 1'b1;
        end
      end
      FULL: begin
        unique case (1'b1)
          accept && consume: main_load = 1'b1;
          accept && !consume: begin
            state_n   = SKID;
            skid_load = 1'b1;
          end
          !accept && consume: state_n = EMPTY;
          default: ;
        endcase
      end
      SKID: begin
        if (consume) begin
          state_n   = FULL;
          main_load = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (rst || flush) begin
      state_n   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // State plus registered handshake/occupancy outputs.
  always_ff @(posedge clk) begin
    state     <= state_n;
    in_ready  <= (state_n != SKID);
    out_valid <= (state_n != EMPTY);
    unique case (state_n)
      EMPTY:   occupancy <= 2'd0;
      FULL:    occupancy <= 2'd1;
      default: occupancy <= 2'd2;
    endcase
  end

  pipe_payload_reg #(.W(P)) u_main (
    .clk  (clk),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_payload_reg #(.W(P)) u_skid (
    .clk  (clk),
    .load (skid_load),
    .d    (in_pl),
    .q    (skid_q)
  );

  assign {m_aluop, m_alusel, m_reg1,
          m_reg2, m_wd, m_wreg} = main_q;

  assign ex_aluop  = out_valid ? m_aluop
                               : ALUOP_W'(NOP_OP);
  assign ex_alusel = out_valid ? m_alusel
                               : ALUSEL_W'(RES_NOP);
  assign ex_reg1   = out_valid ? m_reg1
                               : REG_W'(ZeroWord);
  assign ex_reg2   = out_valid ? m_reg2
                               : REG_W'(ZeroWord);
  assign ex_wd     = out_valid ? m_wd
                               : ADDR_W'(NOPRegAddr);
  assign ex_wreg   = out_valid ? m_wreg : WriteDisable;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed and scoreboarded checks for id_ex_pipe.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [7:0]  id_aluop, ex_aluop;
  logic [2:0]  id_alusel, ex_alusel;
  logic [31:0] id_reg1, id_reg2, ex_reg1, ex_reg2;
  logic [4:0]  id_wd, ex_wd;
  logic        id_wreg, ex_wreg;
  logic        out_valid, out_ready;
  logic [1:0]  occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .id_aluop  (id_aluop),
    .id_alusel (id_alusel),
    .id_reg1   (id_reg1),
    .id_reg2   (id_reg2),
    .id_wd     (id_wd),
    .id_wreg   (id_wreg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ex_aluop  (ex_aluop),
    .ex_alusel (ex_alusel),
    .ex_reg1   (ex_reg1),
    .ex_reg2   (ex_reg2),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [7:0] op,
                       input logic [31:0] r1);
    in_valid  = v;
    id_aluop  = op;
    id_alusel = 3'd1;
    id_reg1   = r1;
    id_reg2   = r1 + 32'd1;
    id_wd     = op[4:0];
    id_wreg   = 1'b1;
  endtask

  logic [39:0] sb[$];
  logic        m_acc, m_con;
  logic [31:0] tag_n;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 32'h0);
    step();
    step();
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aluop", ex_aluop, 0);
    chk("rst_wreg", ex_wreg, 0);
    rst = 1'b0;

    // single op from EMPTY, latency 1
    in_valid = 1'b1;
    id_aluop = 8'h21;
    id_alusel = 3'd2;
    id_reg1 = 32'd5;
    id_reg2 = 32'd7;
    id_wd = 5'd3;
    id_wreg = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("one_valid", out_valid, 1);
    chk("one_aluop", ex_aluop, 8'h21);
    chk("one_alusel", ex_alusel, 3'd2);
    chk("one_reg1", ex_reg1, 5);
    chk("one_reg2", ex_reg2, 7);
    chk("one_wd", ex_wd, 3);
    chk("one_wreg", ex_wreg, 1);
    chk("one_occ", occupancy, 1);
    step();
    chk("one_drain_valid", out_valid, 0);
    chk("one_drain_reg1", ex_reg1, 0);
    chk("one_drain_wd", ex_wd, 0);

    // A then B into skid with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 8'h0A, 32'h100);
    step();
    chk("ab_occ1", occupancy, 1);
    chk("ab_ready1", in_ready, 1);
    drive(1'b1, 8'h0B, 32'h200);
    step();
    chk("ab_occ2", occupancy, 2);
    chk("ab_ready0", in_ready, 0);
    chk("ab_headA", ex_aluop, 8'h0A);
    drive(1'b1, 8'h0C, 32'h300);
    step();
    chk("ab_blocked_occ", occupancy, 2);
    chk("ab_blocked_head", ex_reg1, 32'h100);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ab_B_valid", out_valid, 1);
    chk("ab_B_aluop", ex_aluop, 8'h0B);
    chk("ab_B_reg1", ex_reg1, 32'h200);
    chk("ab_B_occ", occupancy, 1);
    chk("ab_B_ready", in_ready, 1);
    step();
    chk("ab_end_valid", out_valid, 0);
    chk("ab_end_wreg", ex_wreg, 0);
    chk("ab_end_aluop", ex_aluop, 0);

    // streaming 8 ops back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 32'h1000 + i);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_aluop", ex_aluop, 8'h30 + 8'(i));
      chk("stream_reg1", ex_reg1, 32'h1000 + i);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", out_valid, 0);

    // flush while in SKID with an incoming op
    out_ready = 1'b0;
    drive(1'b1, 8'h0D, 32'h400);
    step();
    drive(1'b1, 8'h0E, 32'h500);
    step();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1;
    drive(1'b1, 8'h77, 32'h777);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_aluop", ex_aluop, 0);
    chk("fl_reg1", ex_reg1, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", out_valid, 0);

    // reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 8'h55, 32'h600);
    step();
    chk("rs_pre_occ", occupancy, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_occ", occupancy, 0);
    chk("rs_aluop", ex_aluop, 0);
    chk("rs_reg1", ex_reg1, 0);
    chk("rs_ready", in_ready, 1);

    // random handshakes against a queue model
    tag_n = 32'h8000;
    for (int c = 0; c < 300; c++) begin
      chk("rnd_ready", in_ready, sb.size() < 2);
      chk("rnd_valid", out_valid, sb.size() > 0);
      chk("rnd_occ", occupancy, sb.size());
      if (sb.size() > 0) begin
        chk("rnd_aluop", ex_aluop, sb[0][39:32]);
        chk("rnd_reg1", ex_reg1, sb[0][31:0]);
      end else begin
        chk("rnd_nop", ex_wreg, 0);
      end
      drive(1'($urandom_range(0, 1)),
            8'($urandom), tag_n);
      out_ready = 1'($urandom_range(0, 1));
      m_acc = in_valid && (sb.size() < 2);
      m_con = out_ready && (sb.size() > 0);
      step();
      if (m_con) void'(sb.pop_front());
      if (m_acc) begin
        sb.push_back({id_aluop, id_reg1});
        tag_n++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
